// File: rtl/int_ctrl.sv
// int_ctrl: nested interrupt controller with edge-detected external requests.
// Optional INT_SYNC_EN adds a two-flop synchronizer on irq.
module int_ctrl #(
  parameter int W        = 8,
  parameter int EXT_BASE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [W-EXT_BASE-1:0] irq,
  input  logic                mask_we,
  input  logic [W-1:0]        mask_d,
  input  logic [W-1:0]        s_calli,
  input  logic [W-1:0]        s_reti,
  output logic [W-1:0]        min_bit_s,
  output logic [W-1:0]        min_bit_a,
  output logic [W-1:0]        int_a,
  output logic [W-1:0]        pending_o
);

  localparam int NEXT = W - EXT_BASE;
  localparam logic [W-1:0] INT_ONES =
    {{NEXT{1'b0}}, {EXT_BASE{1'b1}}};
  localparam logic [W-1:0] ONE =
    {{(W-1){1'b0}}, 1'b1};

  function automatic logic [W-1:0] low_bit(
    input logic [W-1:0] x
  );
    return x & (~x + ONE);
  endfunction

  logic [NEXT-1:0] q;
  logic [NEXT-1:0] prev_q, prev_d;
  logic [W-1:0]    edge_v;
  logic [W-1:0]    pend_q, pend_d;
  logic [W-1:0]    act_q, act_d;
  logic [W-1:0]    en_q, en_d;

`ifdef INT_SYNC_EN
  logic [NEXT-1:0] s1_q, s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= irq;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
`else
  // irq must be synchronous to clk in this build
  assign q = irq;
`endif

  always_comb begin
    prev_d = q;
    edge_v = {q & ~prev_q, {EXT_BASE{1'b0}}};
    pend_d = (pend_q & ~s_calli) | edge_v;
    act_d  = (act_q & ~s_reti) | s_calli;
    en_d   = en_q;
    if (mask_we) en_d = mask_d | INT_ONES;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      pend_q <= '0;
      act_q  <= '0;
      en_q   <= INT_ONES;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      en_q   <= en_d;
    end
  end

  // Outputs depend on registers only, so s_calli may be fed from min_bit_s
  assign min_bit_s = low_bit(pend_q & en_q);
  assign min_bit_a = low_bit(act_q);
  assign int_a     = act_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed vector table plus hand-written corner sequences.
module tb_int_ctrl;

`ifdef INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] irq = '0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_d = '0;
  logic [7:0] s_calli = '0;
  logic [7:0] s_reti = '0;
  logic [7:0] min_bit_s, min_bit_a, int_a, pending_o;

  int n_vec = 0;
  int n_err = 0;

  int_ctrl #(.W(8), .EXT_BASE(2)) dut (
    .clk(clk), .reset(reset), .irq(irq),
    .mask_we(mask_we), .mask_d(mask_d),
    .s_calli(s_calli), .s_reti(s_reti),
    .min_bit_s(min_bit_s), .min_bit_a(min_bit_a),
    .int_a(int_a), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       mwe;
    logic [7:0] mask;
    logic [5:0] irq;
    logic [7:0] calli;
    logic [7:0] reti;
    bit         wait_irq;
    logic [7:0] e_s;
    logic [7:0] e_a;
    logic [7:0] e_int;
    logic [7:0] e_pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input string n, input logic mwe, input logic [7:0] m,
    input logic [5:0] ir, input logic [7:0] c,
    input logic [7:0] r, input bit w,
    input logic [7:0] es, input logic [7:0] ea,
    input logic [7:0] ei, input logic [7:0] ep
  );
    vec_t v;
    v.name = n; v.mwe = mwe; v.mask = m; v.irq = ir;
    v.calli = c; v.reti = r; v.wait_irq = w;
    v.e_s = es; v.e_a = ea; v.e_int = ei; v.e_pend = ep;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string n, input logic [7:0] es,
    input logic [7:0] ea, input logic [7:0] ei,
    input logic [7:0] ep
  );
    n_vec++;
    if (min_bit_s !== es || min_bit_a !== ea ||
        int_a !== ei || pending_o !== ep) begin
      n_err++;
      $display("FAIL %s: got s=%h a=%h int=%h pend=%h exp s=%h a=%h int=%h pend=%h",
        n, min_bit_s, min_bit_a, int_a, pending_o,
        es, ea, ei, ep);
    end
  endtask

  task automatic idle(input int n);
    irq = '0; s_calli = '0; s_reti = '0; mask_we = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    add("mask_fc",   1, 8'hFC, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("irq_src5",  0, 0, 6'h08, 0, 0, 1, 8'h20, 8'h00, 8'h00, 8'h20);
    add("call_5",    0, 0, 0, 8'h20, 0, 0, 8'h00, 8'h20, 8'h20, 8'h00);
    add("irq_src2",  0, 0, 6'h01, 0, 0, 1, 8'h04, 8'h20, 8'h20, 8'h04);
    add("call_2",    0, 0, 0, 8'h04, 0, 0, 8'h00, 8'h04, 8'h24, 8'h00);
    add("ret_2",     0, 0, 0, 0, 8'h04, 0, 8'h00, 8'h20, 8'h20, 8'h00);
    add("ret_5",     0, 0, 0, 0, 8'h20, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("mask_03",   1, 8'h03, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("irq_src4m", 0, 0, 6'h04, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h10);
    add("mask_13",   1, 8'h13, 0, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h10);
    add("call_4",    0, 0, 0, 8'h10, 0, 0, 8'h00, 8'h10, 8'h10, 8'h00);
    add("ret_4",     0, 0, 0, 0, 8'h10, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("exc_call0", 0, 0, 0, 8'h01, 0, 0, 8'h00, 8'h01, 8'h01, 8'h00);
    add("ret_inact", 0, 0, 0, 0, 8'h02, 0, 8'h00, 8'h01, 8'h01, 8'h00);
    add("ret_0",     0, 0, 0, 0, 8'h01, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("call_ret6", 0, 0, 0, 8'h40, 8'h40, 0, 8'h00, 8'h40, 8'h40, 8'h00);
    add("ret_6",     0, 0, 0, 0, 8'h40, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add("multi_call",0, 0, 0, 8'h0C, 0, 0, 8'h00, 8'h04, 8'h0C, 8'h00);
    add("multi_ret", 0, 0, 0, 0, 8'h0C, 0, 8'h00, 8'h00, 8'h00, 8'h00);

    #2;
    check("reset_state", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    check("post_reset", 8'h00, 8'h00, 8'h00, 8'h00);

    foreach (tbl[i]) begin
      mask_we = tbl[i].mwe;
      mask_d  = tbl[i].mask;
      irq     = tbl[i].irq;
      s_calli = tbl[i].calli;
      s_reti  = tbl[i].reti;
      step();
      idle(tbl[i].wait_irq ? LAT - 1 : 0);
      mask_we = 1'b0; irq = '0; s_calli = '0; s_reti = '0;
      check(tbl[i].name, tbl[i].e_s, tbl[i].e_a,
            tbl[i].e_int, tbl[i].e_pend);
      idle(tbl[i].wait_irq ? 1 : 0);
    end

    // Source 6: edge lands in the same cycle as its entry
    mask_d = 8'hFC; mask_we = 1'b1;
    step();
    idle(4);
    irq = 6'h10;
    step();
    idle(LAT - 1);
    check("pend_src6", 8'h40, 8'h00, 8'h00, 8'h40);
    idle(4);
    irq = 6'h10;
    if (LAT > 1) begin
      step();
      irq = '0;
      repeat (LAT - 2) step();
    end
    s_calli = 8'h40;
    step();
    irq = '0; s_calli = '0;
    check("edge_and_call6", 8'h40, 8'h40, 8'h40, 8'h40);
    s_calli = 8'h40;
    step();
    s_calli = '0;
    check("recall6", 8'h00, 8'h40, 8'h40, 8'h00);
    s_reti = 8'h40;
    step();
    s_reti = '0;
    check("ret6_clean", 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset mid-operation with irq[0] held high
    s_calli = 8'h24;
    step();
    s_calli = '0;
    check("nest_24", 8'h00, 8'h04, 8'h24, 8'h00);
    irq = 6'h01;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 8'h00, 8'h00, 8'h00, 8'h00);
    step();
    step();
    check("held_reset", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT) step();
    check("irq_after_rst", 8'h00, 8'h00, 8'h00, 8'h04);
    repeat (3) step();
    mask_d = 8'hFC; mask_we = 1'b1;
    step();
    mask_we = 1'b0;
    check("remask_src2", 8'h04, 8'h00, 8'h00, 8'h04);
    s_calli = 8'h04;
    step();
    s_calli = '0;
    check("call_src2", 8'h00, 8'h04, 8'h04, 8'h00);
    repeat (5) step();
    check("single_edge", 8'h00, 8'h04, 8'h04, 8'h00);
    irq = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
